// File: rtl/vector_ls_sequencer_pkg.sv
// Shared types and geometry helpers for the vector load/store sequencer.
// Derived sizes are computed here so the interface, top and decoder agree.
package vector_ls_sequencer_pkg;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    // Scalar words per vector slice.
    function automatic int unsigned calc_spv(int unsigned num_elems, int unsigned elem_size,
                                             int unsigned scalar_size);
        return (num_elems * elem_size) / scalar_size;
    endfunction

    function automatic int unsigned calc_nw(int unsigned spv, int unsigned num_slices);
        return spv * num_slices;
    endfunction

    // Elements packed into one scalar word.
    function automatic int unsigned calc_epw(int unsigned elem_size, int unsigned scalar_size);
        return scalar_size / elem_size;
    endfunction

    function automatic int unsigned idx_width(int unsigned nw);
        return $clog2(nw);
    endfunction

    function automatic int unsigned cnt_width(int unsigned nw);
        return $clog2(nw) + 1;
    endfunction

endpackage

// File: rtl/vector_ls_sequencer_if.sv
// Operation request and word-transfer handshake between the pipeline/memory side
// (master) and the load/store sequencer (slave).
interface vector_ls_sequencer_if
    import vector_ls_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SLICES  = 1,
    parameter int unsigned NUM_ELEMS   = 8,
    parameter int unsigned ELEM_SIZE   = 16,
    parameter int unsigned SCALAR_SIZE = 32
);
    localparam int unsigned SPV = calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE);
    localparam int unsigned NW  = calc_nw(SPV, NUM_SLICES);
    localparam int unsigned IW  = idx_width(NW);
    localparam int unsigned CW  = cnt_width(NW);
    localparam int unsigned SW  = $clog2(SPV);

    logic                  new_op;
    logic                  op_we;
    logic [CW-1:0]         op_count;
    logic [IW-1:0]         op_start;
    logic                  ready;
    logic                  word_valid;
    logic                  word_ack;
    logic [IW-1:0]         word_index;
    logic [NUM_SLICES-1:0] slice_sel;
    logic [SW-1:0]         sel_word;
    logic [SW-1:0]         sel_store_word;
    logic [NUM_ELEMS-1:0]  load_en;
    logic                  store_en;
    logic                  complete;

    modport master (
        output new_op, op_we, op_count, op_start, word_ack,
        input  ready, word_valid, word_index, slice_sel, sel_word, sel_store_word,
               load_en, store_en, complete
    );

    modport slave (
        input  new_op, op_we, op_count, op_start, word_ack,
        output ready, word_valid, word_index, slice_sel, sel_word, sel_store_word,
               load_en, store_en, complete
    );

endinterface

// File: rtl/vector_ls_sequencer_word_decode.sv
// Splits a linear word index into owning slice (one-hot), word-within-slice and
// the element write mask covering that word.
module vector_ls_sequencer_word_decode #(
    parameter int unsigned NUM_SLICES = 1,
    parameter int unsigned NUM_ELEMS  = 8,
    parameter int unsigned SPV        = 4,
    parameter int unsigned EPW        = 2,
    parameter int unsigned IW         = 2,
    parameter int unsigned SW         = 2
) (
    input  logic [IW-1:0]         index,
    output logic [NUM_SLICES-1:0] slice_sel,
    output logic [SW-1:0]         sel_word,
    output logic [NUM_ELEMS-1:0]  elem_mask
);
    logic [31:0] idx;
    logic [31:0] word_in_slice;

    assign idx           = 32'(index);
    assign word_in_slice = idx % SPV;
    assign sel_word      = SW'(word_in_slice);

    always_comb begin
        slice_sel = '0;
        elem_mask = '0;
        for (int s = 0; s < int'(NUM_SLICES); s++) begin
            slice_sel[s] = ((idx / SPV) == 32'(s));
        end
        for (int e = 0; e < int'(NUM_ELEMS); e++) begin
            elem_mask[e] = ((32'(e) / EPW) == word_in_slice);
        end
    end

endmodule

// File: rtl/vector_ls_sequencer.sv
// Vector load/store sequencer: accepts one operation and steps scalar-word transfers
// from a wrapping start index under a valid/ack handshake, then pulses complete.
module vector_ls_sequencer
    import vector_ls_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SLICES  = 1,
    parameter int unsigned NUM_ELEMS   = 8,
    parameter int unsigned ELEM_SIZE   = 16,
    parameter int unsigned SCALAR_SIZE = 32
) (
    input logic                 clk,
    input logic                 reset,
    vector_ls_sequencer_if.slave bus
);
    localparam int unsigned SPV = calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE);
    localparam int unsigned NW  = calc_nw(SPV, NUM_SLICES);
    localparam int unsigned EPW = calc_epw(ELEM_SIZE, SCALAR_SIZE);
    localparam int unsigned IW  = idx_width(NW);
    localparam int unsigned CW  = cnt_width(NW);
    localparam int unsigned SW  = $clog2(SPV);

    state_e               state_q;
    logic [IW-1:0]        index_q;
    logic [CW-1:0]        remaining_q;
    logic                 we_q;
    logic [CW-1:0]        start_count;
    logic [NUM_ELEMS-1:0] elem_mask;
    logic [SW-1:0]        word_sel;
    logic                 xfer_ack;

    // Requests longer than the whole vector are clamped to one full pass.
    assign start_count = (bus.op_count > CW'(NW)) ? CW'(NW) : bus.op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            index_q     <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.new_op) begin
                        we_q        <= bus.op_we;
                        index_q     <= bus.op_start;
                        remaining_q <= start_count;
                        state_q     <= (start_count == '0) ? StDone : StXfer;
                    end
                end
                StXfer: begin
                    if (bus.word_ack) begin
                        index_q     <= (index_q == IW'(NW - 1)) ? '0 : index_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CW'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    vector_ls_sequencer_word_decode #(
        .NUM_SLICES (NUM_SLICES),
        .NUM_ELEMS  (NUM_ELEMS),
        .SPV        (SPV),
        .EPW        (EPW),
        .IW         (IW),
        .SW         (SW)
    ) u_word_decode (
        .index     (index_q),
        .slice_sel (bus.slice_sel),
        .sel_word  (word_sel),
        .elem_mask (elem_mask)
    );

    assign xfer_ack           = (state_q == StXfer) && bus.word_ack;
    assign bus.ready          = (state_q == StIdle);
    assign bus.word_valid     = (state_q == StXfer);
    assign bus.complete       = (state_q == StDone);
    assign bus.word_index     = index_q;
    assign bus.sel_word       = word_sel;
    assign bus.sel_store_word = word_sel;
    assign bus.load_en        = (xfer_ack && !we_q) ? elem_mask : '0;
    assign bus.store_en       = xfer_ack && we_q;

endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Directed bench: one-slice default DUT (NW=4) and a two-slice DUT (NW=8).
module tb_vector_ls_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    vector_ls_sequencer_if #(.NUM_SLICES(1)) ifa ();
    vector_ls_sequencer_if #(.NUM_SLICES(2)) ifb ();

    vector_ls_sequencer #(.NUM_SLICES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    vector_ls_sequencer #(.NUM_SLICES(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.new_op = 0; ifa.op_we = 0; ifa.op_count = '0; ifa.op_start = '0; ifa.word_ack = 0;
        ifb.new_op = 0; ifb.op_we = 0; ifb.op_count = '0; ifb.op_start = '0; ifb.word_ack = 0;
        tick(); tick();
        reset = 1'b0;
        tick(); settle();
        checks++; if (ifa.ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ifa.ready);
        else passed++;
        checks++; if (ifa.word_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ifa.word_valid);
        else passed++;
        checks++; if (ifa.word_index !== 2'd0) $display("FAIL reset_index got=%0d exp=0", ifa.word_index);
        else passed++;
        checks++; if (ifa.slice_sel !== 1'b1) $display("FAIL reset_slice got=%b exp=1", ifa.slice_sel);
        else passed++;
        checks++; if (ifb.slice_sel !== 2'b01) $display("FAIL reset_slice_b got=%b exp=01", ifb.slice_sel);
        else passed++;
        checks++;
        if (ifa.sel_word !== 2'd0 || ifa.sel_store_word !== 2'd0)
            $display("FAIL reset_sel got=%0d/%0d exp=0/0", ifa.sel_word, ifa.sel_store_word);
        else passed++;
        checks++;
        if (ifa.load_en !== 8'h00 || ifa.store_en !== 1'b0 || ifa.complete !== 1'b0)
            $display("FAIL reset_enables got=%h/%0b/%0b exp=00/0/0", ifa.load_en, ifa.store_en,
                     ifa.complete);
        else passed++;
    endtask

    task automatic test_load_basic();
        logic [7:0] exp_en [4];
        exp_en = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        ifa.new_op = 1; ifa.op_we = 0; ifa.op_count = 3'd4; ifa.op_start = 2'd0; ifa.word_ack = 1;
        settle();
        checks++; if (ifa.ready !== 1'b1) $display("FAIL load_c0_ready got=%0b exp=1", ifa.ready);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick(); ifa.new_op = 0; settle();
            checks++;
            if (ifa.word_valid !== 1'b1 || ifa.load_en !== exp_en[i] || ifa.store_en !== 1'b0)
                $display("FAIL load_c%0d got valid=%0b en=%h st=%0b exp valid=1 en=%h st=0",
                         i + 1, ifa.word_valid, ifa.load_en, ifa.store_en, exp_en[i]);
            else passed++;
            checks++;
            if (ifa.word_index !== 2'(i) || ifa.sel_word !== 2'(i))
                $display("FAIL load_idx%0d got=%0d/%0d exp=%0d", i + 1, ifa.word_index,
                         ifa.sel_word, i);
            else passed++;
        end
        tick(); settle();
        checks++;
        if (ifa.complete !== 1'b1 || ifa.word_valid !== 1'b0 || ifa.ready !== 1'b0 ||
            ifa.load_en !== 8'h00)
            $display("FAIL load_c5 got cpl=%0b valid=%0b rdy=%0b en=%h exp 1/0/0/00",
                     ifa.complete, ifa.word_valid, ifa.ready, ifa.load_en);
        else passed++;
        tick(); settle();
        checks++;
        if (ifa.ready !== 1'b1 || ifa.complete !== 1'b0)
            $display("FAIL load_c6 got rdy=%0b cpl=%0b exp 1/0", ifa.ready, ifa.complete);
        else passed++;
        ifa.word_ack = 0;
    endtask

    task automatic test_store_wrap();
        logic [2:0] exp_idx [4];
        logic [1:0] exp_sel [4];
        exp_idx = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_sel = '{2'b10, 2'b10, 2'b01, 2'b01};
        ifb.new_op = 1; ifb.op_we = 1; ifb.op_count = 4'd4; ifb.op_start = 3'd6; ifb.word_ack = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); ifb.new_op = 0; settle();
            checks++;
            if (ifb.word_index !== exp_idx[i] || ifb.slice_sel !== exp_sel[i] ||
                ifb.sel_store_word !== exp_idx[i][1:0])
                $display("FAIL store_c%0d got idx=%0d sel=%b sw=%0d exp idx=%0d sel=%b sw=%0d",
                         i + 1, ifb.word_index, ifb.slice_sel, ifb.sel_store_word, exp_idx[i],
                         exp_sel[i], exp_idx[i][1:0]);
            else passed++;
            checks++;
            if (ifb.store_en !== 1'b1 || ifb.load_en !== 8'h00)
                $display("FAIL store_en_c%0d got st=%0b ld=%h exp 1/00", i + 1, ifb.store_en,
                         ifb.load_en);
            else passed++;
        end
        tick(); settle();
        checks++;
        if (ifb.complete !== 1'b1 || ifb.store_en !== 1'b0)
            $display("FAIL store_c5 got cpl=%0b st=%0b exp 1/0", ifb.complete, ifb.store_en);
        else passed++;
        ifb.word_ack = 0;
        tick();
    endtask

    task automatic test_stall();
        logic [1:0] exp_idx [6];
        logic [7:0] exp_en [6];
        int pulses;
        exp_idx = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        exp_en  = '{8'h00, 8'h0C, 8'h00, 8'h30, 8'h00, 8'hC0};
        pulses = 0;
        ifa.new_op = 1; ifa.op_we = 0; ifa.op_count = 3'd3; ifa.op_start = 2'd1; ifa.word_ack = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); ifa.new_op = 0; ifa.word_ack = (i % 2 == 1); settle();
            if (ifa.load_en != 8'h00) pulses++;
            checks++;
            if (ifa.word_valid !== 1'b1 || ifa.word_index !== exp_idx[i] ||
                ifa.load_en !== exp_en[i])
                $display("FAIL stall_c%0d got valid=%0b idx=%0d en=%h exp 1/%0d/%h", i + 1,
                         ifa.word_valid, ifa.word_index, ifa.load_en, exp_idx[i], exp_en[i]);
            else passed++;
        end
        tick(); ifa.word_ack = 0; settle();
        checks++; if (ifa.complete !== 1'b1) $display("FAIL stall_done got=%0b exp=1", ifa.complete);
        else passed++;
        checks++; if (pulses !== 3) $display("FAIL stall_pulses got=%0d exp=3", pulses);
        else passed++;
        tick();
    endtask

    task automatic test_zero_count();
        ifa.new_op = 1; ifa.op_we = 0; ifa.op_count = 3'd0; ifa.op_start = 2'd2; ifa.word_ack = 1;
        tick(); ifa.new_op = 0; settle();
        checks++;
        if (ifa.complete !== 1'b1 || ifa.word_valid !== 1'b0)
            $display("FAIL zero_c1 got cpl=%0b valid=%0b exp 1/0", ifa.complete, ifa.word_valid);
        else passed++;
        tick(); settle();
        checks++;
        if (ifa.ready !== 1'b1 || ifa.complete !== 1'b0)
            $display("FAIL zero_c2 got rdy=%0b cpl=%0b exp 1/0", ifa.ready, ifa.complete);
        else passed++;
        ifa.word_ack = 0;
    endtask

    // Starts an op on DUT A with ack high; optionally re-requests during the first XFER cycle.
    task automatic run_a(input logic we, input logic [2:0] cnt, input logic [1:0] start,
                         input bit poke, output int xfers, output int done_cycle);
        xfers = 0; done_cycle = -1;
        ifa.new_op = 1; ifa.op_we = we; ifa.op_count = cnt; ifa.op_start = start;
        ifa.word_ack = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            ifa.new_op = (poke && i == 1);
            if (poke && i == 1) begin ifa.op_count = 3'd4; ifa.op_start = 2'd3; end
            settle();
            if (ifa.load_en != 8'h00 || ifa.store_en) xfers++;
            if (ifa.complete) begin done_cycle = i; break; end
        end
        ifa.new_op = 0; ifa.word_ack = 0;
        tick();
    endtask

    task automatic test_saturate();
        int xf, dc;
        run_a(1'b1, 3'd7, 2'd2, 1'b0, xf, dc);
        checks++;
        if (xf !== 4 || dc !== 5) $display("FAIL sat_a got xfers=%0d done=%0d exp 4/5", xf, dc);
        else passed++;
        xf = 0; dc = -1;
        ifb.new_op = 1; ifb.op_we = 1; ifb.op_count = 4'd15; ifb.op_start = 3'd5; ifb.word_ack = 1;
        for (int i = 1; i <= 20; i++) begin
            tick(); ifb.new_op = 0; settle();
            if (ifb.store_en) xf++;
            if (ifb.complete) begin dc = i; break; end
        end
        ifb.word_ack = 0;
        checks++;
        if (xf !== 8 || dc !== 9) $display("FAIL sat_b got xfers=%0d done=%0d exp 8/9", xf, dc);
        else passed++;
        tick();
    endtask

    task automatic test_ignore_new_op();
        int xf, dc;
        run_a(1'b0, 3'd2, 2'd0, 1'b1, xf, dc);
        checks++;
        if (xf !== 2 || dc !== 3) $display("FAIL ignore_op got xfers=%0d done=%0d exp 2/3", xf, dc);
        else passed++;
        settle();
        checks++;
        if (ifa.ready !== 1'b1 || ifa.word_index !== 2'd2)
            $display("FAIL ignore_after got rdy=%0b idx=%0d exp 1/2", ifa.ready, ifa.word_index);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int cpl;
        cpl = 0;
        ifa.new_op = 1; ifa.op_we = 0; ifa.op_count = 3'd4; ifa.op_start = 2'd1; ifa.word_ack = 1;
        tick(); ifa.new_op = 0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; settle();
        checks++;
        if (ifa.ready !== 1'b1 || ifa.word_valid !== 1'b0 || ifa.load_en !== 8'h00 ||
            ifa.store_en !== 1'b0 || ifa.complete !== 1'b0 || ifa.word_index !== 2'd0)
            $display("FAIL rst_mid got rdy=%0b valid=%0b en=%h st=%0b cpl=%0b idx=%0d exp 1/0/00/0/0/0",
                     ifa.ready, ifa.word_valid, ifa.load_en, ifa.store_en, ifa.complete,
                     ifa.word_index);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            if (ifa.complete || ifa.word_valid) cpl++;
        end
        checks++; if (cpl !== 0) $display("FAIL rst_mid_quiet got=%0d exp=0", cpl);
        else passed++;
        ifa.word_ack = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_store_wrap();
        test_stall();
        test_zero_count();
        test_saturate();
        test_ignore_new_op();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
